// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file scheduler.
// Forwarding build is selected with REGFILE_SCHED_FWD_EN.
package regfile_sched_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int RD_LATENCY = 2;
    localparam int NUM_REGS   = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    localparam reg_addr_t REG_ZERO = {REG_AW{1'b0}};

    typedef enum logic {
        WR_SRC_ALU = 1'b0,
        WR_SRC_LSU = 1'b1
    } wr_src_e;

    // "reg" is a keyword, so the destination field is called addr
    typedef struct packed {
        reg_addr_t addr;
        xdata_t    data;
    } wr_req_t;

    function automatic logic addr_hit(input logic v, input reg_addr_t a, input reg_addr_t b);
        return v && (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// A same-cycle write to a source unblocks it; set beats clear, flush beats set.
module regfile_scoreboard
    import regfile_sched_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      set_valid,
    input  reg_addr_t set_reg,
    input  logic      clr_valid,
    input  reg_addr_t clr_reg,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_blocked,
    output logic      rs2_blocked
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = {NUM_REGS{1'b0}};
        end else begin
            if (clr_valid) begin
                pend_d[clr_reg] = 1'b0;
            end else begin
                pend_d = pend_d;
            end
            if (set_valid) begin
                pend_d[set_reg] = 1'b1;
            end else begin
                pend_d = pend_d;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= {NUM_REGS{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rs1_blocked = (rs1 != REG_ZERO) && pend_q[rs1] && !addr_hit(clr_valid, clr_reg, rs1);
        rs2_blocked = (rs2 != REG_ZERO) && pend_q[rs2] && !addr_hit(clr_valid, clr_reg, rs2);
    end

endmodule

// File: rtl/regfile_scheduler.sv
// Register-file front end: round-robin write port, scoreboard stall, 2-cycle read pipeline.
// REGFILE_SCHED_FWD_EN: forward in-window writes; otherwise stall on recent writes.
module regfile_scheduler
    import regfile_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              sb_set_valid,
    input  logic [REG_AW-1:0] sb_set_reg,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [REG_AW-1:0] rd_rs1,
    input  logic [REG_AW-1:0] rd_rs2,
    output logic              rd_rsp_valid,
    output logic [XLEN-1:0]   rd_rs1v,
    output logic [XLEN-1:0]   rd_rs2v,
    input  logic              alu_wr_valid,
    input  logic              lsu_wr_valid,
    output logic              alu_wr_ready,
    output logic              lsu_wr_ready,
    input  logic [REG_AW-1:0] alu_wr_reg,
    input  logic [REG_AW-1:0] lsu_wr_reg,
    input  logic [XLEN-1:0]   alu_wr_data,
    input  logic [XLEN-1:0]   lsu_wr_data,
    output logic [REG_AW-1:0] rf_rs1,
    output logic [REG_AW-1:0] rf_rs2,
    input  logic [XLEN-1:0]   rf_rs1v,
    input  logic [XLEN-1:0]   rf_rs2v,
    output logic              rf_wren,
    output logic [REG_AW-1:0] rf_wd_reg,
    output logic [XLEN-1:0]   rf_wdv
);

    wr_src_e rr_q, rr_d, win_s;
    wr_req_t wr_s;
    logic    wr_grant_s, wr_live_s;
    logic    sb_blk1_s, sb_blk2_s, hz1_s, hz2_s, rd_acc_s;
    logic    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

    // rr_q names the side preferred when both requesters are valid
    always_comb begin
        case ({alu_wr_valid, lsu_wr_valid})
            2'b10:   win_s = WR_SRC_ALU;
            2'b01:   win_s = WR_SRC_LSU;
            default: win_s = rr_q;
        endcase
        wr_grant_s   = alu_wr_valid | lsu_wr_valid;
        alu_wr_ready = wr_grant_s && (win_s == WR_SRC_ALU);
        lsu_wr_ready = wr_grant_s && (win_s == WR_SRC_LSU);
        if (win_s == WR_SRC_LSU) begin
            wr_s.addr = lsu_wr_reg;
            wr_s.data = lsu_wr_data;
        end else begin
            wr_s.addr = alu_wr_reg;
            wr_s.data = alu_wr_data;
        end
        wr_live_s = wr_grant_s && (wr_s.addr != REG_ZERO);
        if (wr_grant_s) begin
            rr_d = (win_s == WR_SRC_ALU) ? WR_SRC_LSU : WR_SRC_ALU;
        end else begin
            rr_d = rr_q;
        end
    end

    assign rf_wren   = wr_grant_s;
    assign rf_wd_reg = wr_s.addr;
    assign rf_wdv    = wr_s.data;
    assign rf_rs1    = rd_rs1;
    assign rf_rs2    = rd_rs2;

    regfile_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .set_valid   (sb_set_valid),
        .set_reg     (sb_set_reg),
        .clr_valid   (wr_live_s),
        .clr_reg     (wr_s.addr),
        .rs1         (rd_rs1),
        .rs2         (rd_rs2),
        .rs1_blocked (sb_blk1_s),
        .rs2_blocked (sb_blk2_s)
    );

    always_comb begin
        rd_req_ready = !(sb_blk1_s || sb_blk2_s || hz1_s || hz2_s);
        rd_acc_s     = rd_req_valid && rd_req_ready;
        s1_valid_d   = flush ? 1'b0 : rd_acc_s;
        s2_valid_d   = flush ? 1'b0 : s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q       <= WR_SRC_ALU;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign rd_rsp_valid = s2_valid_q;

`ifdef REGFILE_SCHED_FWD_EN
    reg_addr_t [1:0] rs_s, s1_rs_q, s1_rs_d;
    logic      [1:0] s1_hit_q, s1_hit_d, s2_hit_q, s2_hit_d;
    xdata_t    [1:0] s1_dat_q, s1_dat_d, s2_dat_q, s2_dat_d;

    assign hz1_s = 1'b0;
    assign hz2_s = 1'b0;

    // Stage 1 captures the write of the accept cycle; stage 2 lets the next write override it
    always_comb begin
        rs_s = {rd_rs2, rd_rs1};
        for (int i = 0; i < 2; i++) begin
            s1_rs_d[i]  = rs_s[i];
            s1_hit_d[i] = addr_hit(wr_grant_s, wr_s.addr, rs_s[i]);
            s1_dat_d[i] = s1_hit_d[i] ? wr_s.data : {XLEN{1'b0}};
            if (addr_hit(wr_grant_s, wr_s.addr, s1_rs_q[i])) begin
                s2_hit_d[i] = 1'b1;
                s2_dat_d[i] = wr_s.data;
            end else begin
                s2_hit_d[i] = s1_hit_q[i];
                s2_dat_d[i] = s1_dat_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_rs_q  <= {2{REG_ZERO}};
            s1_hit_q <= 2'b00;
            s1_dat_q <= {2{{XLEN{1'b0}}}};
            s2_hit_q <= 2'b00;
            s2_dat_q <= {2{{XLEN{1'b0}}}};
        end else begin
            s1_rs_q  <= s1_rs_d;
            s1_hit_q <= s1_hit_d;
            s1_dat_q <= s1_dat_d;
            s2_hit_q <= s2_hit_d;
            s2_dat_q <= s2_dat_d;
        end
    end

    always_comb begin
        rd_rs1v = s2_valid_q ? (s2_hit_q[0] ? s2_dat_q[0] : rf_rs1v) : {XLEN{1'b0}};
        rd_rs2v = s2_valid_q ? (s2_hit_q[1] ? s2_dat_q[1] : rf_rs2v) : {XLEN{1'b0}};
    end
`else
    logic      h1_v_q, h1_v_d, h2_v_q, h2_v_d;
    reg_addr_t h1_reg_q, h1_reg_d, h2_reg_q, h2_reg_d;

    // Writes from this cycle and the two before are not yet visible at the regfile read port
    always_comb begin
        h1_v_d   = wr_live_s;
        h1_reg_d = wr_s.addr;
        h2_v_d   = h1_v_q;
        h2_reg_d = h1_reg_q;
        hz1_s = addr_hit(wr_live_s, wr_s.addr, rd_rs1) || addr_hit(h1_v_q, h1_reg_q, rd_rs1)
             || addr_hit(h2_v_q, h2_reg_q, rd_rs1);
        hz2_s = addr_hit(wr_live_s, wr_s.addr, rd_rs2) || addr_hit(h1_v_q, h1_reg_q, rd_rs2)
             || addr_hit(h2_v_q, h2_reg_q, rd_rs2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h1_v_q   <= 1'b0;
            h1_reg_q <= REG_ZERO;
            h2_v_q   <= 1'b0;
            h2_reg_q <= REG_ZERO;
        end else begin
            h1_v_q   <= h1_v_d;
            h1_reg_q <= h1_reg_d;
            h2_v_q   <= h2_v_d;
            h2_reg_q <= h2_reg_d;
        end
    end

    always_comb begin
        rd_rs1v = s2_valid_q ? rf_rs1v : {XLEN{1'b0}};
        rd_rs2v = s2_valid_q ? rf_rs2v : {XLEN{1'b0}};
    end
`endif

endmodule

// File: doc/regfile_scheduler.md
Name: regfile_scheduler

Overview:
- Controller in front of the 32x32 register file. Its read path has 2-cycle registered latency; its single write port has no reset.
- Arbitrates the single write port between two writeback requesters, ALU and LSU, using round-robin.
- Keeps a pending-write scoreboard and stalls reads whose sources are reserved.
- Sequences reads through the 2-cycle read pipeline and forwards writes that land inside the read window.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width (2**REG_AW registers).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  clears scoreboard and in-flight reads.
- sb_set_valid  in  1  decode reserves a destination register.
- sb_set_reg  in  REG_AW  register to reserve.
- rd_req_valid  in  1  read request.
- rd_req_ready  out  1  read accepted this cycle.
- rd_rs1, rd_rs2  in  REG_AW  source addresses.
- rd_rsp_valid  out  1  response valid.
- rd_rs1v, rd_rs2v  out  XLEN  response data.
- alu_wr_valid, lsu_wr_valid  in  1  write requests.
- alu_wr_ready, lsu_wr_ready  out  1  write grants.
- alu_wr_reg, lsu_wr_reg  in  REG_AW  destination.
- alu_wr_data, lsu_wr_data  in  XLEN  data.
- rf_rs1, rf_rs2  out  REG_AW  to regfile read addresses.
- rf_rs1v, rf_rs2v  in  XLEN  from regfile.
- rf_wren  out  1  to regfile write enable.
- rf_wd_reg  out  REG_AW  to regfile write address.
- rf_wdv  out  XLEN  to regfile write data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Scoreboard cleared, read pipeline valids cleared, round-robin pointer favours ALU.
  - rd_rsp_valid=0; rd_rs1v/rd_rs2v=0.
  - Regfile contents are untouched; in-flight responses are dropped.
- flush has the same effect except the round-robin pointer is kept. A flush coincident with sb_set_valid: flush wins.
- Write arbitration (combinational grant, one write per cycle):
  - Only one valid requester: grant it.
  - Both valid: grant the side not granted last; the pointer updates only on a grant.
  - rf_wren = any grant; rf_wd_reg/rf_wdv are muxed from the winner.
  - Requesters hold valid and payload stable until ready.
  - A write to reg 0 is granted and passed through; it is never forwarded and never clears a scoreboard bit.
- Scoreboard:
  - One pending bit per register; bit 0 is hardwired 0.
  - A granted write to reg r clears pend[r] at the clock edge.
  - sb_set_valid sets pend[sb_set_reg]. Set and clear of the same register in the same cycle: set wins.
- Read issue:
  - rd_req_ready = NOT (src1 blocked OR src2 blocked).
  - srcN is blocked if its address is non-zero AND pend[srcN]=1 AND no write to that register is granted in the current cycle.
  - rf_rs1/rf_rs2 = rd_rs1/rd_rs2 continuously.
  - Accepted in cycle c: stage1 valid in c+1, stage2 valid in c+2.
  - rd_rsp_valid is asserted in cycle c+2 with rf_rs*v merged with forwarded data.
  - Throughput is one read per cycle.
- Forwarding:
  - The response reflects every write granted in cycles c and c+1 to a matching non-zero address; the c+1 write overrides the c write.
  - Writes granted in c+2 are not reflected.
  - Forward data is captured into stage registers. The regfile's c+2 output is never relied on for those two writes.

Optional Feature:
- Macro REGFILE_SCHED_FWD_EN.
- Defined: forwarding as above.
- Undefined: no forwarding muxes. The block keeps a 2-entry history of granted write addresses (cycles c-1 and c-2 relative to the request). rd_req_ready is additionally deasserted if a non-zero source matches a write granted this cycle or either history entry. rd_rs*v come directly from rf_rs*v.

Decomposition:
- Package regfile_sched_pkg holds:
  - XLEN, REG_AW, RD_LATENCY=2;
  - typedef reg_addr_t;
  - enum wr_src_e {WR_SRC_ALU, WR_SRC_LSU};
  - struct wr_req_t {reg, data}.
- Sub-module regfile_scoreboard: pending bits, set/clear/flush, and the two block lookups.

Test Plan:
- Arbitration: ALU and LSU both valid for 4 cycles with regs 5/6 -> grants alternate ALU, LSU, ALU, LSU after reset; rf_wren=1 every cycle.
- Scoreboard: set reg 7, read rs1=7 -> rd_req_ready=0 until the ALU write to 7 is granted. In the grant cycle ready=1, and rd_rs1v two cycles later equals the written data 32'hDEADBEEF.
- Forwarding: read rs2=9 in cycle c, LSU writes 9=32'h11 in c and ALU writes 9=32'h22 in c+1 -> rd_rs2v=32'h22 at c+2. A write of 32'h33 in c+2 is not reflected.
- Register 0: set reg 0, then write 0=32'hFFFF, then read rs1=0 -> never stalls, rd_rs1v=0.
- Set/clear collision: set and granted write to reg 4 in the same cycle -> pend[4]=1 afterwards, so a read of 4 stalls.
- Reset and flush: rst_n low while two reads are in flight -> rd_rsp_valid=0 the following cycles, pending bits clear, first grant goes to ALU. flush with pend[3]=1 -> read of 3 accepted the next cycle.
